// File: rtl/dog_sprite_compositor_if.sv
// Pixel-path bundle between the timing/game side and the sprite compositor.
// The master drives pixel position, sync and per-dog sprite buses; the slave returns colour and delayed sync.
interface dog_sprite_compositor_if #(parameter int N = 4);
    logic              frame_tick;
    logic              active;
    logic [9:0]        px;
    logic [8:0]        py;
    logic              hs_in;
    logic              vs_in;
    logic [1:0]        bg_mode;
    logic [N*10-1:0]   posx_bus;
    logic [N*9-1:0]    posy_bus;
    logic [N*8-1:0]    hits_bus;
    logic [N*3-1:0]    col_bus;
    logic [2:0]        vga_r;
    logic [2:0]        vga_g;
    logic [1:0]        vga_b;
    logic              hs_out;
    logic              vs_out;

    modport master (
        output frame_tick, active, px, py, hs_in, vs_in, bg_mode,
               posx_bus, posy_bus, hits_bus, col_bus,
        input  vga_r, vga_g, vga_b, hs_out, vs_out
    );

    modport slave (
        input  frame_tick, active, px, py, hs_in, vs_in, bg_mode,
               posx_bus, posy_bus, hits_bus, col_bus,
        output vga_r, vga_g, vga_b, hs_out, vs_out
    );
endinterface

// File: rtl/dog_sprite_compositor.sv
// N-dog sprite compositor: per-frame shadowed sprite state, damage blink, and a
// two-stage overlap/compositing pipeline with sync delayed to match colour.
module dog_sprite_compositor #(
    parameter int   N            = 4,
    parameter int   BOX_W        = 48,
    parameter int   BOX_H        = 32,
    parameter int   BAR_W        = 6,
    parameter int   BLINK_FRAMES = 8,
    parameter logic SYNC_IDLE    = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    dog_sprite_compositor_if.slave vif
);

    logic [9:0] sh_x      [N];
    logic [8:0] sh_y      [N];
    logic [7:0] sh_hits   [N];
    logic [2:0] sh_col    [N];
    logic [3:0] blink_cnt [N];
    logic       shadow_valid;

    logic [N-1:0] s1_box;
    logic [N-1:0] s1_bar;
    logic [N-1:0] s1_blink;
    logic [2:0]   s1_col [N];
    logic         s1_active;
    logic         s1_hs;
    logic         s1_vs;
    logic [1:0]   s1_bg;
    logic [4:0]   s1_pxh;
    logic [3:0]   s1_pyh;

    logic [2:0] mix_r;
    logic [2:0] mix_g;
    logic [1:0] mix_b;

    // Widened compares so a box near the right/bottom edge never wraps to 0.
    function automatic logic box_test(input logic [9:0] xp, input logic [8:0] yp,
                                      input logic [9:0] x0, input logic [8:0] y0);
        return (xp >= x0) && ({1'b0, xp} < ({1'b0, x0} + 11'(BOX_W)))
            && (yp >= y0) && ({1'b0, yp} < ({1'b0, y0} + 10'(BOX_H)));
    endfunction

    function automatic logic bar_test(input logic [9:0] xp, input logic [8:0] yp,
                                      input logic [9:0] x0, input logic [8:0] y0,
                                      input logic [7:0] hits);
        logic [13:0] prod;
        logic [5:0]  h;
        prod = 14'(hits) * 14'(BOX_H);
        h    = prod[13:8];
        return (xp >= x0) && ({1'b0, xp} < ({1'b0, x0} + 11'(BAR_W)))
            && (yp < y0) && (({1'b0, yp} + 10'(h)) >= {1'b0, y0});
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                sh_x[i]      <= '0;
                sh_y[i]      <= '0;
                sh_hits[i]   <= '0;
                sh_col[i]    <= '0;
                blink_cnt[i] <= '0;
            end
        end else if (vif.frame_tick) begin
            shadow_valid <= 1'b1;
            for (int i = 0; i < N; i++) begin
                sh_x[i]    <= vif.posx_bus[10*i +: 10];
                sh_y[i]    <= vif.posy_bus[9*i +: 9];
                sh_hits[i] <= vif.hits_bus[8*i +: 8];
                sh_col[i]  <= vif.col_bus[3*i +: 3];
                if (vif.hits_bus[8*i +: 8] > sh_hits[i])
                    blink_cnt[i] <= 4'(BLINK_FRAMES);
                else if (blink_cnt[i] != 4'd0)
                    blink_cnt[i] <= blink_cnt[i] - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_box    <= '0;
            s1_bar    <= '0;
            s1_blink  <= '0;
            s1_active <= 1'b0;
            s1_hs     <= SYNC_IDLE;
            s1_vs     <= SYNC_IDLE;
            s1_bg     <= '0;
            s1_pxh    <= '0;
            s1_pyh    <= '0;
            for (int i = 0; i < N; i++) s1_col[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                s1_box[i]   <= shadow_valid && box_test(vif.px, vif.py, sh_x[i], sh_y[i]);
                s1_bar[i]   <= shadow_valid && bar_test(vif.px, vif.py, sh_x[i], sh_y[i], sh_hits[i]);
                s1_blink[i] <= (blink_cnt[i] != 4'd0) && blink_cnt[i][0];
                s1_col[i]   <= sh_col[i];
            end
            s1_active <= vif.active;
            s1_hs     <= vif.hs_in;
            s1_vs     <= vif.vs_in;
            s1_bg     <= vif.bg_mode;
            s1_pxh    <= vif.px[9:5];
            s1_pyh    <= vif.py[8:5];
        end
    end

    // Later assignments override earlier ones: background, boxes by index, bars, blanking.
    always_comb begin
        mix_r = 3'b000;
        mix_g = 3'b000;
        mix_b = 2'b00;
        case (s1_bg)
            2'd0: begin
                mix_r = s1_pxh[4:2];
                mix_g = s1_pyh[3:1];
                mix_b = {s1_pxh[1] ^ s1_pyh[1], s1_pxh[0] ^ s1_pyh[0]};
            end
            2'd2: begin
                if (s1_pxh[0] ^ s1_pyh[0]) begin
                    mix_r = 3'b111;
                    mix_g = 3'b111;
                    mix_b = 2'b11;
                end
            end
            2'd3: mix_b = 2'b11;
            default: ;
        endcase
        for (int i = 0; i < N; i++) begin
            if (s1_box[i]) begin
                if (s1_blink[i]) begin
                    mix_r = 3'b111;
                    mix_g = 3'b111;
                    mix_b = 2'b11;
                end else begin
                    mix_r = {s1_col[i][2], s1_col[i][2], s1_col[i][1]};
                    mix_g = {s1_col[i][1], s1_col[i][1], s1_col[i][0]};
                    mix_b = {s1_col[i][0], s1_col[i][1]};
                end
            end
        end
        if (|s1_bar) begin
            mix_r = 3'b111;
            mix_g = 3'b000;
            mix_b = 2'b00;
        end
        if (!s1_active) begin
            mix_r = 3'b000;
            mix_g = 3'b000;
            mix_b = 2'b00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vif.vga_r  <= '0;
            vif.vga_g  <= '0;
            vif.vga_b  <= '0;
            vif.hs_out <= SYNC_IDLE;
            vif.vs_out <= SYNC_IDLE;
        end else begin
            vif.vga_r  <= mix_r;
            vif.vga_g  <= mix_g;
            vif.vga_b  <= mix_b;
            vif.hs_out <= s1_hs;
            vif.vs_out <= s1_vs;
        end
    end

endmodule

// File: tb/tb_dog_sprite_compositor.sv
// Bench for dog_sprite_compositor: directed scenarios plus randomized frames,
// checked against a pixel-level reference model of the compositing rules.
module tb_dog_sprite_compositor;
    localparam int N = 4, BOX_W = 48, BOX_H = 32, BAR_W = 6, BLINK = 8;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
        logic       hs;
        logic       vs;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dog_sprite_compositor_if #(.N(N)) bus();

    dog_sprite_compositor #(
        .N(N), .BOX_W(BOX_W), .BOX_H(BOX_H), .BAR_W(BAR_W),
        .BLINK_FRAMES(BLINK), .SYNC_IDLE(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vif(bus)
    );

    int bx[N], by[N], bh[N], bc[N];
    int m_x[N], m_y[N], m_h[N], m_c[N], m_bl[N];
    bit m_valid;
    pix_t exp_q[$];
    pix_t g, w;
    int total = 0;
    int bad = 0;

    always_comb begin
        bus.posx_bus = '0;
        bus.posy_bus = '0;
        bus.hits_bus = '0;
        bus.col_bus  = '0;
        for (int i = 0; i < N; i++) begin
            bus.posx_bus[10*i +: 10] = 10'(bx[i]);
            bus.posy_bus[9*i +: 9]   = 9'(by[i]);
            bus.hits_bus[8*i +: 8]   = 8'(bh[i]);
            bus.col_bus[3*i +: 3]    = 3'(bc[i]);
        end
    end

    function automatic pix_t model_pix(bit act, int x, int y, int bg, bit hs, bit vs);
        pix_t p;
        int x5, x6, y5, y6, h;
        logic [2:0] c;
        p = '0;
        p.hs = hs;
        p.vs = vs;
        if (!act) return p;
        x5 = (x / 32) % 2; x6 = (x / 64) % 2;
        y5 = (y / 32) % 2; y6 = (y / 64) % 2;
        case (bg)
            0: begin
                p.r = 3'((x / 128) % 8);
                p.g = 3'((y / 64) % 8);
                p.b = {1'(x6 ^ y6), 1'(x5 ^ y5)};
            end
            2: if ((x5 ^ y5) == 1) begin p.r = 3'd7; p.g = 3'd7; p.b = 2'd3; end
            3: p.b = 2'd3;
            default: ;
        endcase
        if (m_valid) begin
            for (int i = 0; i < N; i++) begin
                if (x >= m_x[i] && x < m_x[i] + BOX_W && y >= m_y[i] && y < m_y[i] + BOX_H) begin
                    if (m_bl[i] % 2 == 1) begin
                        p.r = 3'd7; p.g = 3'd7; p.b = 2'd3;
                    end else begin
                        c = 3'(m_c[i]);
                        p.r = {c[2], c[2], c[1]};
                        p.g = {c[1], c[1], c[0]};
                        p.b = {c[0], c[1]};
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                h = m_h[i] * BOX_H / 256;
                if (h > 0 && x >= m_x[i] && x < m_x[i] + BAR_W && y < m_y[i] && y >= m_y[i] - h) begin
                    p.r = 3'd7; p.g = 3'd0; p.b = 2'd0;
                end
            end
        end
        return p;
    endfunction

    task automatic model_tick();
        for (int i = 0; i < N; i++) begin
            if (bh[i] > m_h[i]) m_bl[i] = BLINK;
            else if (m_bl[i] > 0) m_bl[i] = m_bl[i] - 1;
            m_x[i] = bx[i]; m_y[i] = by[i]; m_h[i] = bh[i]; m_c[i] = bc[i];
        end
        m_valid = 1'b1;
    endtask

    // Drives one pixel now; returns the output that belongs to the previous call's pixel.
    task automatic cycle(input bit act, input int x, input int y, input int bg, input bit tick,
                         input bit hs, input bit vs, output pix_t got, output pix_t want);
        bus.active     = act;
        bus.px         = 10'(x);
        bus.py         = 9'(y);
        bus.bg_mode    = 2'(bg);
        bus.frame_tick = tick;
        bus.hs_in      = hs;
        bus.vs_in      = vs;
        exp_q.push_back(model_pix(act, x, y, bg, hs, vs));
        if (tick) model_tick();
        @(negedge clk);
        got  = {bus.vga_r, bus.vga_g, bus.vga_b, bus.hs_out, bus.vs_out};
        want = exp_q.pop_front();
    endtask

    task automatic release_reset();
        @(negedge clk);
        bus.active = 1'b0; bus.frame_tick = 1'b0; bus.hs_in = 1'b1; bus.vs_in = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_h[i] = 0; m_c[i] = 0; m_bl[i] = 0;
        end
        m_valid = 1'b0;
        exp_q.delete();
        exp_q.push_back(pix_t'({8'd0, 1'b1, 1'b1}));
    endtask

    task automatic park_dogs();
        for (int i = 0; i < N; i++) begin
            bx[i] = 1023; by[i] = 511; bh[i] = 0; bc[i] = 0;
        end
    endtask

    task automatic test_reset();
        bus.active = 1'b0; bus.px = '0; bus.py = '0; bus.bg_mode = 2'd1; bus.frame_tick = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.hs_in = 1'($urandom); bus.vs_in = 1'($urandom);
            total++;
            if ({bus.vga_r, bus.vga_g, bus.vga_b} !== 8'd0 || bus.hs_out !== 1'b1 || bus.vs_out !== 1'b1) begin
                bad++;
                $display("FAIL reset_hold got rgb=%h hs=%b vs=%b want rgb=00 hs=1 vs=1",
                         {bus.vga_r, bus.vga_g, bus.vga_b}, bus.hs_out, bus.vs_out);
            end
        end
        release_reset();
        bx[0] = 5; by[0] = 5; bc[0] = 7; bh[0] = 200;
        for (int k = 0; k < 300; k++) begin
            cycle(1'($urandom_range(0, 7) != 0), $urandom_range(0, 80), $urandom_range(0, 60), 1, 1'b0,
                  1'($urandom), 1'($urandom), g, w);
            total++;
            if (g !== w) begin bad++; $display("FAIL no_tick_black got=%h want=%h", g, w); end
        end
    endtask

    task automatic test_box();
        int tx[5] = '{100, 148, 100, 147, 99};
        int ty[5] = '{50, 50, 82, 81, 50};
        logic [7:0] trgb[5] = '{8'b110_001_10, 8'h00, 8'h00, 8'b110_001_10, 8'h00};
        park_dogs();
        bx[0] = 100; by[0] = 50; bc[0] = 5;
        cycle(1'b0, 0, 0, 1, 1'b1, 1'b1, 1'b1, g, w);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, tx[k], ty[k], 1, 1'b0, 1'b1, 1'b1, g, w);
            cycle(1'b0, 0, 0, 1, 1'b0, 1'b1, 1'b1, g, w);
            total++;
            if (g !== w) begin bad++; $display("FAIL box_model (%0d,%0d) got=%h want=%h", tx[k], ty[k], g, w); end
            total++;
            if ({g.r, g.g, g.b} !== trgb[k]) begin
                bad++; $display("FAIL box_const (%0d,%0d) got=%b want=%b", tx[k], ty[k], {g.r, g.g, g.b}, trgb[k]);
            end
        end
    endtask

    task automatic test_bar();
        int tx[5] = '{100, 105, 100, 106, 100};
        int ty[5] = '{19, 49, 18, 30, 50};
        logic [7:0] trgb[5] = '{8'b111_000_00, 8'b111_000_00, 8'h00, 8'h00, 8'b110_001_10};
        bh[0] = 255;
        cycle(1'b0, 0, 0, 1, 1'b1, 1'b1, 1'b1, g, w);
        for (int y = 16; y <= 52; y++) begin
            for (int x = 98; x <= 108; x++) begin
                cycle(1'b1, x, y, $urandom_range(0, 3), 1'b0, 1'($urandom), 1'($urandom), g, w);
                total++;
                if (g !== w) begin bad++; $display("FAIL bar_scan got=%h want=%h", g, w); end
            end
        end
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, tx[k], ty[k], 1, 1'b0, 1'b1, 1'b1, g, w);
            cycle(1'b0, 0, 0, 1, 1'b0, 1'b1, 1'b1, g, w);
            total++;
            if ({g.r, g.g, g.b} !== trgb[k]) begin
                bad++; $display("FAIL bar_const (%0d,%0d) got=%b want=%b", tx[k], ty[k], {g.r, g.g, g.b}, trgb[k]);
            end
        end
    endtask

    task automatic test_bar_clip();
        int tx[4] = '{100, 105, 100, 106};
        int ty[4] = '{0, 9, 511, 5};
        logic [7:0] trgb[4] = '{8'b111_000_00, 8'b111_000_00, 8'h00, 8'h00};
        by[0] = 10;
        cycle(1'b0, 0, 0, 1, 1'b1, 1'b1, 1'b1, g, w);
        for (int r = 0; r < 20; r++) begin
            for (int x = 98; x <= 107; x++) begin
                cycle(1'b1, x, (r < 13) ? r : 492 + r, 1, 1'b0, 1'b1, 1'b0, g, w);
                total++;
                if (g !== w) begin bad++; $display("FAIL clip_scan got=%h want=%h", g, w); end
            end
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, tx[k], ty[k], 1, 1'b0, 1'b1, 1'b1, g, w);
            cycle(1'b0, 0, 0, 1, 1'b0, 1'b1, 1'b1, g, w);
            total++;
            if ({g.r, g.g, g.b} !== trgb[k]) begin
                bad++; $display("FAIL clip_const (%0d,%0d) got=%b want=%b", tx[k], ty[k], {g.r, g.g, g.b}, trgb[k]);
            end
        end
    endtask

    task automatic test_blink();
        logic [7:0] want_rgb;
        bx[0] = 200; by[0] = 100; bc[0] = 1;
        bx[2] = 220; by[2] = 110; bc[2] = 6; bh[2] = 0;
        cycle(1'b0, 0, 0, 1, 1'b1, 1'b1, 1'b1, g, w);
        bh[2] = 10;
        for (int k = 0; k <= 10; k++) begin
            cycle(1'b0, 0, 0, 1, 1'b1, 1'b1, 1'b1, g, w);
            cycle(1'b1, 230, 120, 1, 1'b0, 1'b1, 1'b1, g, w);
            cycle(1'b0, 0, 0, 1, 1'b0, 1'b1, 1'b1, g, w);
            want_rgb = (k % 2 == 1 && k <= 7) ? 8'hFF : 8'b111_110_01;
            total++;
            if ({g.r, g.g, g.b} !== want_rgb) begin
                bad++; $display("FAIL blink_frame%0d got=%b want=%b", k, {g.r, g.g, g.b}, want_rgb);
            end
            total++;
            if (g !== w) begin bad++; $display("FAIL blink_model frame%0d got=%h want=%h", k, g, w); end
        end
    endtask

    task automatic test_right_edge();
        int tx[5] = '{1000, 1023, 999, 0, 23};
        logic [7:0] trgb[5] = '{8'b001_110_01, 8'b001_110_01, 8'b000_000_11, 8'b000_000_11, 8'b000_000_11};
        park_dogs();
        bx[3] = 1000; by[3] = 200; bc[3] = 2;
        cycle(1'b0, 0, 0, 3, 1'b1, 1'b1, 1'b1, g, w);
        for (int k = 0; k < 65; k++) begin
            cycle(1'b1, (k < 34) ? 990 + k : k - 34, 210, 3, 1'b0, 1'($urandom), 1'b1, g, w);
            total++;
            if (g !== w) begin bad++; $display("FAIL edge_scan got=%h want=%h", g, w); end
        end
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, tx[k], 210, 3, 1'b0, 1'b1, 1'b1, g, w);
            cycle(1'b0, 0, 0, 3, 1'b0, 1'b1, 1'b1, g, w);
            total++;
            if ({g.r, g.g, g.b} !== trgb[k]) begin
                bad++; $display("FAIL edge_const x=%0d got=%b want=%b", tx[k], {g.r, g.g, g.b}, trgb[k]);
            end
        end
        // Move coincides with the tick: that cycle's pixel still sees the old position.
        bx[3] = 500;
        cycle(1'b1, 1010, 210, 3, 1'b1, 1'b1, 1'b1, g, w);
        cycle(1'b1, 1010, 210, 3, 1'b0, 1'b1, 1'b1, g, w);
        total++;
        if ({g.r, g.g, g.b} !== 8'b001_110_01) begin bad++; $display("FAIL tick_old_pos got=%b want=00111001", {g.r, g.g, g.b}); end
        bx[3] = 700;
        cycle(1'b1, 510, 210, 3, 1'b0, 1'b1, 1'b1, g, w);
        total++;
        if ({g.r, g.g, g.b} !== 8'b000_000_11) begin bad++; $display("FAIL tick_new_pos_old got=%b want=00000011", {g.r, g.g, g.b}); end
        cycle(1'b0, 0, 0, 3, 1'b0, 1'b1, 1'b1, g, w);
        total++;
        if ({g.r, g.g, g.b} !== 8'b001_110_01) begin bad++; $display("FAIL tick_new_pos got=%b want=00111001", {g.r, g.g, g.b}); end
        total++;
        if (g !== w) begin bad++; $display("FAIL bus_hold_model got=%h want=%h", g, w); end
    endtask

    task automatic test_reset_midframe();
        cycle(1'b1, 510, 210, 3, 1'b0, 1'b0, 1'b0, g, w);
        cycle(1'b1, 510, 210, 3, 1'b0, 1'b0, 1'b0, g, w);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.vga_r, bus.vga_g, bus.vga_b} !== 8'd0 || bus.hs_out !== 1'b1 || bus.vs_out !== 1'b1) begin
            bad++;
            $display("FAIL midframe_reset got rgb=%h hs=%b vs=%b want rgb=00 hs=1 vs=1",
                     {bus.vga_r, bus.vga_g, bus.vga_b}, bus.hs_out, bus.vs_out);
        end
        release_reset();
        for (int k = 0; k < 40; k++) begin
            cycle(1'b1, 500 + k, 210, 3, 1'b0, 1'($urandom), 1'($urandom), g, w);
            total++;
            if (g !== w) begin bad++; $display("FAIL post_reset_bg got=%h want=%h", g, w); end
        end
        cycle(1'b1, 710, 210, 3, 1'b1, 1'b1, 1'b1, g, w);
        cycle(1'b1, 710, 210, 3, 1'b0, 1'b1, 1'b1, g, w);
        total++;
        if ({g.r, g.g, g.b} !== 8'b000_000_11) begin bad++; $display("FAIL post_reset_tick_pix got=%b want=00000011", {g.r, g.g, g.b}); end
        cycle(1'b0, 0, 0, 3, 1'b0, 1'b1, 1'b1, g, w);
        total++;
        if ({g.r, g.g, g.b} !== 8'b001_110_01) begin bad++; $display("FAIL post_reset_drawn got=%b want=00111001", {g.r, g.g, g.b}); end
    endtask

    task automatic test_random();
        int d, x, y;
        for (int k = 0; k < 3000; k++) begin
            bit tick;
            tick = ($urandom_range(0, 63) == 0);
            if (tick || $urandom_range(0, 15) == 0) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        bx[i] = $urandom_range(0, 1023);
                        by[i] = $urandom_range(0, 511);
                    end
                    case ($urandom_range(0, 2))
                        0: bh[i] = (bh[i] + 40 > 255) ? 255 : bh[i] + $urandom_range(1, 40);
                        1: bh[i] = $urandom_range(0, bh[i]);
                        default: ;
                    endcase
                    bc[i] = $urandom_range(0, 7);
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 511);
            end else begin
                d = $urandom_range(0, N - 1);
                x = m_x[d] + $urandom_range(0, 60) - 8;
                y = m_y[d] + $urandom_range(0, 70) - 34;
                x = (x < 0) ? 0 : ((x > 1023) ? 1023 : x);
                y = (y < 0) ? 0 : ((y > 511) ? 511 : y);
            end
            cycle(1'($urandom_range(0, 9) != 0), x, y, $urandom_range(0, 3), tick,
                  1'($urandom), 1'($urandom), g, w);
            total++;
            if (g !== w) begin bad++; $display("FAIL random cycle=%0d got=%h want=%h", k, g, w); end
        end
    endtask

    initial begin
        park_dogs();
        bus.hs_in = 1'b1; bus.vs_in = 1'b1;
        test_reset();
        test_box();
        test_bar();
        test_bar_clip();
        test_blink();
        test_right_edge();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
